// File: rtl/led_step_pkg.sv
// Shared types and helpers for the running-LED step generator.
package led_step_pkg;

    typedef logic [1:0] speed_lvl_t;

    localparam speed_lvl_t SPEED_MIN = 2'd0;
    localparam speed_lvl_t SPEED_MAX = 2'd3;

    // Slowest level gets the largest shift, so level 0 runs at BASE_DIV*8.
    function automatic logic [1:0] period_shift(input speed_lvl_t lvl);
        return SPEED_MAX - lvl;
    endfunction

endpackage

// File: rtl/led_debounce.sv
// Two-flop synchronizer, counting debouncer and rising-edge pulse for one raw button.
module led_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;
    logic          accept;

    assign accept = (sync2 != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

    // Any cycle where the synchronized input agrees with the level restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            rise  <= accept && sync2;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (accept) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/led_step_gen.sv
// Button-controlled step pulse generator for a running-LED chain.
module led_step_gen
    import led_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int BASE_DIV        = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_speed,
    input  logic       btn_dir,
    input  logic       btn_pause,
    output logic       step,
    output logic       dir,
    output logic [1:0] speed_lvl,
    output logic       paused
);

    localparam int PW = $clog2((BASE_DIV << 3) + 1);

    logic          speed_ev;
    logic          dir_ev;
    logic          pause_ev;
    logic [PW-1:0] count;
    logic [PW-1:0] period;
    logic          terminal;
    logic          run;

    led_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_speed (
        .clk(clk), .reset(reset), .btn(btn_speed), .rise(speed_ev)
    );

    led_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dir (
        .clk(clk), .reset(reset), .btn(btn_dir), .rise(dir_ev)
    );

    led_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause (
        .clk(clk), .reset(reset), .btn(btn_pause), .rise(pause_ev)
    );

    // A pause event, in either direction, freezes the counter for its own clock.
    always_comb begin
        period   = PW'(BASE_DIV) << period_shift(speed_lvl);
        terminal = (count == period - PW'(1));
        run      = !paused && !pause_ev;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            step      <= 1'b0;
            dir       <= 1'b0;
            speed_lvl <= SPEED_MIN;
            paused    <= 1'b0;
            count     <= '0;
        end else begin
            step <= 1'b0;
            if (dir_ev)
                dir <= ~dir;
            if (pause_ev)
                paused <= ~paused;
            if (speed_ev) begin
                speed_lvl <= (speed_lvl == SPEED_MAX) ? SPEED_MIN : speed_lvl + 2'd1;
                count     <= '0;
            end else if (run) begin
                if (terminal) begin
                    count <= '0;
                    step  <= 1'b1;
                end else begin
                    count <= count + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_led_step_gen.sv
// Scoreboard bench: stimulus pushes expected step/state events, a negedge monitor pops and checks them.
module tb_led_step_gen;

    typedef struct {
        int         cyc;
        logic [3:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_speed;
    logic       btn_dir;
    logic       btn_pause;
    logic       step;
    logic       dir;
    logic [1:0] speed_lvl;
    logic       paused;

    int   cyc = 0;
    int   base = 0;
    int   tests = 0;
    int   fails = 0;
    bit   monEn = 1'b0;
    exp_t stepQ[$];
    exp_t stateQ[$];
    logic [3:0] prevState = 4'b0000;

    led_step_gen dut (
        .clk(clk), .reset(reset), .btn_speed(btn_speed), .btn_dir(btn_dir),
        .btn_pause(btn_pause), .step(step), .dir(dir), .speed_lvl(speed_lvl),
        .paused(paused)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests = tests + 1;
        if (actual != expected) begin
            fails = fails + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc - base);
        end
    endtask

    task automatic waitUntil(input int c);
        while ((cyc - base) < c) @(negedge clk);
    endtask

    task automatic pushSteps(input int first, input int period, input int n, input logic d);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.cyc = first + i * period;
            e.val = {3'b000, d};
            stepQ.push_back(e);
        end
    endtask

    task automatic pushState(input int c, input logic [3:0] v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        stateQ.push_back(e);
    endtask

    // Raw press at cycle 'at' held for 'hold' clocks; optional expected state change.
    task automatic applyStimulus(input int at, input logic sp, input logic dr, input logic pa,
                                 input int hold, input bit hasExp, input int expCyc,
                                 input logic [3:0] expVal);
        waitUntil(at);
        btn_speed = sp;
        btn_dir   = dr;
        btn_pause = pa;
        if (hasExp)
            pushState(expCyc, expVal);
        waitUntil(at + hold);
        btn_speed = 1'b0;
        btn_dir   = 1'b0;
        btn_pause = 1'b0;
    endtask

    // Monitor: every step pulse and every change of {dir, speed_lvl, paused} consumes one expectation.
    always @(negedge clk) begin
        if (monEn) begin
            logic [3:0] cur;
            exp_t e;
            if (step) begin
                if (stepQ.size() == 0) begin
                    tests = tests + 1;
                    fails = fails + 1;
                    $display("[TB] FAIL unexpected_step: step=1 at cycle %0d, none expected", cyc - base);
                end else begin
                    e = stepQ.pop_front();
                    checkOutput("step_cycle", cyc - base, e.cyc);
                    checkOutput("step_dir", int'(dir), int'(e.val[0]));
                end
            end
            cur = {dir, speed_lvl, paused};
            if (cur != prevState) begin
                if (stateQ.size() == 0) begin
                    tests = tests + 1;
                    fails = fails + 1;
                    $display("[TB] FAIL unexpected_state: got %b at cycle %0d, none expected", cur, cyc - base);
                end else begin
                    e = stateQ.pop_front();
                    checkOutput("state_cycle", cyc - base, e.cyc);
                    checkOutput("state_value", int'(cur), int'(e.val));
                end
                prevState = cur;
            end
        end
    end

    initial begin
        reset     = 1'b1;
        btn_speed = 1'b0;
        btn_dir   = 1'b0;
        btn_pause = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_step", int'(step), 0);
        checkOutput("reset_dir", int'(dir), 0);
        checkOutput("reset_speed", int'(speed_lvl), 0);
        checkOutput("reset_paused", int'(paused), 0);
        reset = 1'b0;
        base  = cyc;
        monEn = 1'b1;

        // Idle after reset: level 0 period 32.
        pushSteps(32, 32, 6, 1'b0);
        waitUntil(200);

        // Speed cycling; press-to-effect latency is 7 clocks with default debounce.
        pushSteps(223, 16, 1, 1'b0);
        pushSteps(245, 8, 3, 1'b0);
        pushSteps(273, 4, 7, 1'b0);
        pushSteps(331, 32, 2, 1'b0);
        pushSteps(395, 32, 1, 1'b1);
        pushSteps(427, 32, 1, 1'b0);
        applyStimulus(200, 1'b1, 1'b0, 1'b0, 10, 1'b1, 207, 4'b0010);
        applyStimulus(230, 1'b1, 1'b0, 1'b0, 10, 1'b1, 237, 4'b0100);
        applyStimulus(262, 1'b1, 1'b0, 1'b0, 10, 1'b1, 269, 4'b0110);
        applyStimulus(292, 1'b1, 1'b0, 1'b0, 10, 1'b1, 299, 4'b0000);

        // Direction: short glitch ignored, clean press, then a toggle landing on a step.
        applyStimulus(340, 1'b0, 1'b1, 1'b0, 2, 1'b0, 0, 4'b0000);
        applyStimulus(370, 1'b0, 1'b1, 1'b0, 10, 1'b1, 377, 4'b1000);
        applyStimulus(420, 1'b0, 1'b1, 1'b0, 10, 1'b1, 427, 4'b0000);

        // Pause at count 10, resume 22 clocks before the next step.
        pushSteps(499, 32, 2, 1'b0);
        applyStimulus(431, 1'b0, 1'b0, 1'b1, 10, 1'b1, 438, 4'b0001);
        applyStimulus(470, 1'b0, 1'b0, 1'b1, 10, 1'b1, 477, 4'b0000);

        // Simultaneous speed and pause, then unpause at level 1.
        pushSteps(603, 16, 1, 1'b0);
        applyStimulus(540, 1'b1, 1'b0, 1'b1, 10, 1'b1, 547, 4'b0011);
        applyStimulus(580, 1'b0, 1'b0, 1'b1, 10, 1'b1, 587, 4'b0010);

        // Reset mid-period with btn_speed held through release.
        waitUntil(612);
        btn_speed = 1'b1;
        waitUntil(613);
        reset = 1'b1;
        pushState(614, 4'b0000);
        waitUntil(615);
        checkOutput("midreset_step", int'(step), 0);
        checkOutput("midreset_speed", int'(speed_lvl), 0);
        waitUntil(616);
        reset = 1'b0;
        pushState(623, 4'b0010);
        pushSteps(639, 16, 4, 1'b0);
        waitUntil(700);
        btn_speed = 1'b0;

        checkOutput("steps_left", stepQ.size(), 0);
        checkOutput("states_left", stateQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
